// File: rtl/uart_rx_ext_if.sv
// Output handshake bundle of the UART receiver: received word, status flags and
// the consumer's READY. The receiver owns the master side.
interface uart_rx_ext_if #(
  parameter int unsigned pDataBits = 8
);
  logic [pDataBits-1:0] DATA;
  logic                 VALID;
  logic                 READY;
  logic                 FERR;
  logic                 PERR;
  logic                 OVR;

  modport master (
    output DATA, VALID, FERR, PERR, OVR,
    input  READY
  );

  modport slave (
    input  DATA, VALID, FERR, PERR, OVR,
    output READY
  );
endinterface

// File: rtl/uart_rx_ext.sv
// Parametrised UART receiver: 2-FF synchroniser, 3-sample mid-bit majority vote,
// optional parity, 1-2 checked stop bits, VALID/READY output with overrun flag.
module uart_rx_ext #(
  parameter int unsigned pClk      = 50000000,
  parameter int unsigned pBaud     = 9600,
  parameter int unsigned pDataBits = 8,
  parameter int unsigned pParity   = 0,
  parameter int unsigned pStopBits = 1
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          EN,
  input  logic          RX,
  output logic          BUSY,
  uart_rx_ext_if.master m
);

  localparam int unsigned pTop  = pClk / pBaud - 1;
  localparam int unsigned pHalf = pTop / 2;
  localparam int unsigned CntW  = $clog2(pTop + 1);
  localparam int unsigned IdxW  = 4;

  localparam logic [CntW-1:0] CntTop = CntW'(pTop);
  localparam logic [CntW-1:0] CntS0  = CntW'(pHalf - 1);
  localparam logic [CntW-1:0] CntS1  = CntW'(pHalf);
  localparam logic [CntW-1:0] CntDec = CntW'(pHalf + 1);
  localparam logic [IdxW-1:0] IdxLastData = IdxW'(pDataBits - 1);
  localparam logic [IdxW-1:0] IdxLastStop = IdxW'(pStopBits - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  state_e               state_q, state_d;
  logic                 sync1_q, sync1_d;
  logic                 rxs_q, rxs_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [1:0]           smp_q, smp_d;
  logic [pDataBits-1:0] shift_q, shift_d;
  logic                 ferr_acc_q, ferr_acc_d;
  logic                 perr_acc_q, perr_acc_d;
  logic                 armed_q, armed_d;
  logic [pDataBits-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_q, perr_d;
  logic                 ovr_q, ovr_d;

  logic maj;
  logic wrap;
  logic decide;
  logic done;
  logic done_ferr;

  // Two stored samples plus the live one form the vote on the decision cycle.
  assign maj       = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs_q) | (smp_q[1] & rxs_q);
  assign wrap      = (cnt_q == CntTop);
  assign decide    = (cnt_q == CntDec);
  assign done_ferr = ferr_acc_q | ~maj;

  always_comb begin
    sync1_d    = RX;
    rxs_d      = sync1_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    smp_d      = smp_q;
    shift_d    = shift_q;
    ferr_acc_d = ferr_acc_q;
    perr_acc_d = perr_acc_q;
    armed_d    = armed_q;
    done       = 1'b0;

    if (state_q != ST_IDLE) begin
      cnt_d = wrap ? '0 : cnt_q + CntW'(1);
      if (cnt_q == CntS0) smp_d[0] = rxs_q;
      if (cnt_q == CntS1) smp_d[1] = rxs_q;
    end

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (rxs_q) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d    = ST_START;
          ferr_acc_d = 1'b0;
          perr_acc_d = 1'b0;
        end
      end
      ST_START: begin
        if (decide && maj) begin
          state_d = ST_IDLE;
        end else if (wrap) begin
          state_d = ST_DATA;
          idx_d   = '0;
        end
      end
      ST_DATA: begin
        if (decide) shift_d = {maj, shift_q[pDataBits-1:1]};
        if (wrap) begin
          if (idx_q == IdxLastData) begin
            idx_d   = '0;
            state_d = (pParity != 0) ? ST_PARITY : ST_STOP;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      ST_PARITY: begin
        if (decide) perr_acc_d = ((^shift_q) ^ maj) != (pParity == 1);
        if (wrap) begin
          idx_d   = '0;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        // Leave on the last stop bit's decision, half a bit early, so a
        // back-to-back start edge is never missed.
        if (decide) begin
          if (idx_q == IdxLastStop) begin
            done    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ferr_acc_d = done_ferr;
          end
        end
        if (wrap && !done) idx_d = idx_q + IdxW'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = ferr_q;
    perr_d  = perr_q;
    ovr_d   = ovr_q;

    if (valid_q && m.READY) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end

    if (done) begin
      if (!valid_q || m.READY) begin
        data_d  = shift_q;
        ferr_d  = done_ferr;
        perr_d  = perr_acc_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
      // A framing error usually means break/line low: wait for idle high first.
      if (done_ferr) armed_d = 1'b0;
    end

    if (!EN) begin
      sync1_d    = 1'b1;
      rxs_d      = 1'b1;
      state_d    = ST_IDLE;
      cnt_d      = '0;
      idx_d      = '0;
      smp_d      = '0;
      shift_d    = '0;
      ferr_acc_d = 1'b0;
      perr_acc_d = 1'b0;
      armed_d    = 1'b1;
      data_d     = '0;
      valid_d    = 1'b0;
      ferr_d     = 1'b0;
      perr_d     = 1'b0;
      ovr_d      = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q    <= 1'b1;
      rxs_q      <= 1'b1;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      smp_q      <= '0;
      shift_q    <= '0;
      ferr_acc_q <= 1'b0;
      perr_acc_q <= 1'b0;
      armed_q    <= 1'b1;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      rxs_q      <= rxs_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      smp_q      <= smp_d;
      shift_q    <= shift_d;
      ferr_acc_q <= ferr_acc_d;
      perr_acc_q <= perr_acc_d;
      armed_q    <= armed_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      perr_q     <= perr_d;
      ovr_q      <= ovr_d;
    end
  end

  assign m.DATA  = data_q;
  assign m.VALID = valid_q;
  assign m.FERR  = ferr_q;
  assign m.PERR  = perr_q;
  assign m.OVR   = ovr_q;
  assign BUSY    = (state_q != ST_IDLE);

endmodule
